// File: rtl/serial_parity_rx_if.sv
// Bit-serial link into the parity receiver plus its word-level results.
// in_valid qualifies in_bit; there is no backpressure, so every valid bit is consumed on its edge.
interface serial_parity_rx_if #(
   parameter int DATA_W = 8
);
   logic              in_bit;
   logic              in_valid;
   logic [DATA_W-1:0] data;
   logic              done;
   logic              par_err;
   logic              frame_err;
   logic              busy;
   logic [1:0]        state_dbg;

   modport master (
      output in_bit, in_valid,
      input  data, done, par_err, frame_err, busy, state_dbg
   );

   modport slave (
      input  in_bit, in_valid,
      output data, done, par_err, frame_err, busy, state_dbg
   );
endinterface

// File: rtl/serial_parity_rx.sv
// Receives start / DATA_W data bits LSB first / parity / stop frames and
// reports the word with parity and framing error flags.
module serial_parity_rx #(
   parameter int DATA_W   = 8,
   parameter bit EVEN_PAR = 1'b1
) (
   input  logic               clk,
   input  logic               reset,
   serial_parity_rx_if.slave  rx
);
   localparam int CW = $clog2(DATA_W) + 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(DATA_W - 1);
   localparam logic PAR_FLIP = ~EVEN_PAR;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_DATA = 2'd1,
      ST_PAR  = 2'd2,
      ST_STOP = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              acc_q, acc_d;
   logic              perr_q, perr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              done_q, done_d;
   logic              par_err_q, par_err_d;
   logic              frame_err_q, frame_err_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         shreg_q     <= '0;
         cnt_q       <= '0;
         acc_q       <= 1'b0;
         perr_q      <= 1'b0;
         data_q      <= '0;
         done_q      <= 1'b0;
         par_err_q   <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         shreg_q     <= shreg_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         perr_q      <= perr_d;
         data_q      <= data_d;
         done_q      <= done_d;
         par_err_q   <= par_err_d;
         frame_err_q <= frame_err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (rx.in_valid) begin
         case (state_q)
            ST_IDLE: if (!rx.in_bit) state_d = ST_DATA;
            ST_DATA: if (cnt_q == LAST_CNT) state_d = ST_PAR;
            ST_PAR:  state_d = ST_STOP;
            ST_STOP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // Datapath: everything except done holds on stall cycles; done is a single-cycle pulse.
   always_comb begin
      shreg_d     = shreg_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      perr_d      = perr_q;
      data_d      = data_q;
      done_d      = 1'b0;
      par_err_d   = par_err_q;
      frame_err_d = frame_err_q;
      if (rx.in_valid) begin
         case (state_q)
            ST_IDLE: begin
               if (!rx.in_bit) begin
                  shreg_d = '0;
                  cnt_d   = '0;
                  acc_d   = 1'b0;
               end
            end
            ST_DATA: begin
               shreg_d = (shreg_q >> 1) | (DATA_W'(rx.in_bit) << (DATA_W - 1));
               acc_d   = acc_q ^ rx.in_bit;
               cnt_d   = cnt_q + CW'(1);
            end
            ST_PAR: begin
               // Odd parity flips the compare, making it an XNOR of accumulator and parity bit.
               perr_d = acc_q ^ rx.in_bit ^ PAR_FLIP;
            end
            ST_STOP: begin
               data_d      = shreg_q;
               par_err_d   = perr_q;
               frame_err_d = ~rx.in_bit;
               done_d      = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      rx.busy      = (state_q != ST_IDLE);
      rx.state_dbg = state_q;
      rx.data      = data_q;
      rx.done      = done_q;
      rx.par_err   = par_err_q;
      rx.frame_err = frame_err_q;
   end
endmodule

// File: tb/tb_serial_parity_rx.sv
// Drives an even-parity and an odd-parity receiver with directed and random frames
// and compares every cycle against frame-level expectations.
module tb_serial_parity_rx;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   serial_parity_rx_if #(.DATA_W(8)) if0 ();
   serial_parity_rx_if #(.DATA_W(8)) if1 ();

   serial_parity_rx #(.DATA_W(8), .EVEN_PAR(1'b1)) dut0 (.clk(clk), .reset(reset), .rx(if0));
   serial_parity_rx #(.DATA_W(8), .EVEN_PAR(1'b0)) dut1 (.clk(clk), .reset(reset), .rx(if1));

   typedef struct {
      logic [7:0] data;
      logic       perr;
      logic       ferr;
      int         cyc;
   } frame_t;

   frame_t     exp_q0[$];
   frame_t     exp_q1[$];
   logic       exp_busy [2];
   logic [7:0] held_data [2];
   logic       held_perr [2];
   logic       held_ferr [2];
   int         last_done [2];
   int         cyc = 0;
   bit         mon_en = 1'b0;
   int         checks = 0;
   int         errors = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Frame-level parity rule: count ones over data plus parity bit.
   function automatic logic model_perr(input int u, input logic [7:0] word, input logic p);
      int ones;
      ones = $countones(word) + int'(p);
      return (u == 0) ? (ones % 2 != 0) : (ones % 2 == 0);
   endfunction

   task automatic mon_unit(input int u, input logic d, input logic [7:0] dat,
                           input logic pe, input logic fe, input logic bz);
      frame_t f;
      int     qs;
      chk($sformatf("u%0d_busy", u), 32'(bz), 32'(exp_busy[u]));
      if (d === 1'b1) begin
         qs = (u == 0) ? exp_q0.size() : exp_q1.size();
         if (qs == 0) begin
            chk($sformatf("u%0d_spurious_done", u), 32'd1, 32'd0);
         end else begin
            f = (u == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            last_done[u] = cyc;
            chk($sformatf("u%0d_done_cycle", u), 32'(cyc), 32'(f.cyc));
            held_data[u] = f.data;
            held_perr[u] = f.perr;
            held_ferr[u] = f.ferr;
         end
      end else if (d !== 1'b0) begin
         chk($sformatf("u%0d_done_x", u), 32'(d), 32'd0);
      end
      chk($sformatf("u%0d_data", u), 32'(dat), 32'(held_data[u]));
      chk($sformatf("u%0d_par_err", u), 32'(pe), 32'(held_perr[u]));
      chk($sformatf("u%0d_frame_err", u), 32'(fe), 32'(held_ferr[u]));
   endtask

   always @(posedge clk) begin
      #1;
      cyc++;
      if (mon_en) begin
         mon_unit(0, if0.done, if0.data, if0.par_err, if0.frame_err, if0.busy);
         mon_unit(1, if1.done, if1.data, if1.par_err, if1.frame_err, if1.busy);
      end
   end

   task automatic drive(input int u, input logic b, input logic v);
      @(negedge clk);
      if (u == 0) begin
         if0.in_bit = b; if0.in_valid = v; if1.in_valid = 1'b0;
      end else begin
         if1.in_bit = b; if1.in_valid = v; if0.in_valid = 1'b0;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         if0.in_valid = 1'b0;
         if1.in_valid = 1'b0;
      end
   endtask

   task automatic clear_expect();
      for (int u = 0; u < 2; u++) begin
         exp_busy[u] = 1'b0; held_data[u] = 8'h00; held_perr[u] = 1'b0; held_ferr[u] = 1'b0;
      end
   endtask

   task automatic do_reset(input int n);
      @(negedge clk);
      reset = 1'b1;
      if0.in_valid = 1'b0;
      if1.in_valid = 1'b0;
      clear_expect();
      repeat (n) @(negedge clk);
      reset = 1'b0;
   endtask

   // mode 0: every cycle valid; 1: one stall after each bit; 2: random stalls.
   task automatic send_frame(input int u, input logic [7:0] word, input logic p,
                             input logic s, input int mode, output int start_cyc);
      frame_t f;
      logic   b;
      start_cyc = 0;
      for (int k = 0; k < 11; k++) begin
         if (k == 0)      b = 1'b0;
         else if (k <= 8) b = word[k-1];
         else if (k == 9) b = p;
         else             b = s;
         drive(u, b, 1'b1);
         if (k == 0) begin
            start_cyc = cyc;
            exp_busy[u] = 1'b1;
         end
         if (k == 10) begin
            exp_busy[u] = 1'b0;
            f.data = word; f.perr = model_perr(u, word, p); f.ferr = ~s; f.cyc = cyc + 1;
            if (u == 0) exp_q0.push_back(f); else exp_q1.push_back(f);
         end
         if (k < 10 && (mode == 1 || (mode == 2 && $urandom_range(0, 2) == 0)))
            drive(u, 1'($urandom), 1'b0);
      end
   endtask

   initial begin
      int sc, sc2;
      logic [7:0] w;
      reset = 1'b1;
      if0.in_bit = 1'b1; if0.in_valid = 1'b0;
      if1.in_bit = 1'b1; if1.in_valid = 1'b0;
      clear_expect();
      last_done[0] = 0; last_done[1] = 0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      chk("rst_done", 32'(if0.done), 32'd0);
      chk("rst_busy", 32'(if0.busy), 32'd0);
      chk("rst_data", 32'(if0.data), 32'd0);
      mon_en = 1'b1;
      idle(2);

      send_frame(0, 8'hA5, 1'b0, 1'b1, 0, sc);
      idle(3);
      chk("a5_latency", 32'(last_done[0] - sc), 32'd11);

      send_frame(0, 8'hA5, 1'b1, 1'b1, 0, sc);
      send_frame(0, 8'h07, 1'b1, 1'b1, 0, sc);
      idle(2);
      send_frame(0, 8'h3C, 1'b0, 1'b0, 0, sc);
      idle(2);
      send_frame(0, 8'h3C, 1'b0, 1'b1, 0, sc);
      idle(2);

      send_frame(0, 8'hA5, 1'b0, 1'b1, 1, sc);
      idle(3);
      chk("stall_latency", 32'(last_done[0] - sc), 32'd21);

      // Abort after the fourth data bit of 0x5A.
      w = 8'h5A;
      drive(0, 1'b0, 1'b1);
      exp_busy[0] = 1'b1;
      for (int k = 0; k < 4; k++) drive(0, w[k], 1'b1);
      do_reset(1);
      idle(2);
      send_frame(0, 8'h5A, 1'b0, 1'b1, 0, sc);
      idle(3);

      send_frame(1, 8'h00, 1'b1, 1'b1, 0, sc);
      send_frame(1, 8'hFF, 1'b1, 1'b1, 0, sc2);
      idle(3);
      chk("b2b_latency", 32'(last_done[1] - sc2), 32'd11);
      chk("b2b_start_on_done", 32'(sc2 - sc), 32'd11);

      for (int i = 0; i < 40; i++) begin
         int u;
         u = $urandom_range(0, 1);
         send_frame(u, 8'($urandom), 1'($urandom), ($urandom_range(0, 5) != 0),
                    $urandom_range(0, 2), sc);
         repeat ($urandom_range(0, 2)) begin
            if ($urandom_range(0, 1) == 0) drive(u, 1'b1, 1'b1);
            else drive(u, 1'($urandom), 1'b0);
         end
      end
      idle(4);
      chk("q0_drained", 32'(exp_q0.size()), 32'd0);
      chk("q1_drained", 32'(exp_q1.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
